// File: rtl/proc_mem_req_arbiter.sv
// Two-to-one memory request arbiter with source tagging, response routing,
// per-port outstanding caps and a sticky orphan-response flag.
module proc_mem_req_arbiter #(
  parameter int unsigned p_max_outstanding = 4,
  parameter int unsigned p_req_nbits       = 77,
  parameter int unsigned p_resp_nbits      = 45
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    domain,
  output logic                    mem_domain,

  input  logic [p_req_nbits-1:0]  in0_req_msg,
  input  logic                    in0_req_val,
  output logic                    in0_req_rdy,

  input  logic [p_req_nbits-1:0]  in1_req_msg,
  input  logic                    in1_req_val,
  output logic                    in1_req_rdy,

  output logic [p_req_nbits-1:0]  out_req_msg,
  output logic                    out_req_val,
  input  logic                    out_req_rdy,

  input  logic [p_resp_nbits-1:0] mem_resp_msg,
  input  logic                    mem_resp_val,
  output logic                    mem_resp_rdy,

  output logic [p_resp_nbits-1:0] out0_resp_msg,
  output logic                    out0_resp_val,
  input  logic                    out0_resp_rdy,

  output logic [p_resp_nbits-1:0] out1_resp_msg,
  output logic                    out1_resp_val,
  input  logic                    out1_resp_rdy,

  output logic [3:0]              cnt0,
  output logic [3:0]              cnt1,
  output logic                    err
);

  localparam int unsigned CNT_W   = 4;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(p_max_outstanding);

  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic             prio_q, prio_d;
  logic             lock_q, lock_d;
  logic             locked_port_q, locked_port_d;
  logic             err_q, err_d;

  logic             elig0, elig1;
  logic             grant_val, grant;
  logic             req_fire, resp_fire, resp_port;
  logic [p_req_nbits-1:0] sel_req_msg;

  // Counter step: +1 on request fire, -1 on response fire, clamped to [0, cap].
  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic dec);
    logic [CNT_W-1:0] r;
    r = c;
    if (inc && !dec && (c < MAX_CNT)) r = c + CNT_W'(1);
    else if (dec && !inc && (c != '0)) r = c - CNT_W'(1);
    return r;
  endfunction

  assign mem_domain = domain;

  // Grant selection: a held lock overrides eligibility and the pointer.
  always_comb begin
    elig0     = in0_req_val && (cnt0_q < MAX_CNT);
    elig1     = in1_req_val && (cnt1_q < MAX_CNT);
    grant_val = 1'b0;
    grant     = 1'b0;
    if (lock_q) begin
      grant_val = 1'b1;
      grant     = locked_port_q;
    end else if (elig0 && elig1) begin
      grant_val = 1'b1;
      grant     = prio_q;
    end else if (elig0 || elig1) begin
      grant_val = 1'b1;
      grant     = elig1;
    end
  end

  always_comb begin
    sel_req_msg = grant ? in1_req_msg : in0_req_msg;
    out_req_msg = {sel_req_msg[p_req_nbits-1:74], {7'b0, grant}, sel_req_msg[65:0]};
    out_req_val = grant_val && !reset;
    in0_req_rdy = out_req_val && out_req_rdy && !grant;
    in1_req_rdy = out_req_val && out_req_rdy && grant;
  end

  // Response routing on opaque bit 0; the opaque field is cleared on the way back.
  always_comb begin
    resp_port     = mem_resp_msg[34];
    out0_resp_msg = {mem_resp_msg[p_resp_nbits-1:42], 8'b0, mem_resp_msg[33:0]};
    out1_resp_msg = out0_resp_msg;
    out0_resp_val = mem_resp_val && !resp_port && !reset;
    out1_resp_val = mem_resp_val && resp_port && !reset;
    mem_resp_rdy  = (resp_port ? out1_resp_rdy : out0_resp_rdy) && !reset;
  end

  always_comb begin
    req_fire      = out_req_val && out_req_rdy;
    resp_fire     = mem_resp_val && mem_resp_rdy;
    prio_d        = prio_q;
    lock_d        = lock_q;
    locked_port_d = locked_port_q;
    err_d         = err_q;

    cnt0_d = next_cnt(cnt0_q, req_fire && !grant, resp_fire && !resp_port);
    cnt1_d = next_cnt(cnt1_q, req_fire && grant,  resp_fire && resp_port);

    if (req_fire) begin
      prio_d = !grant;
      lock_d = 1'b0;
    end else if (out_req_val) begin
      lock_d        = 1'b1;
      locked_port_d = grant;
    end

    if (resp_fire && ((resp_port ? cnt1_q : cnt0_q) == '0)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q        <= '0;
      cnt1_q        <= '0;
      prio_q        <= 1'b0;
      lock_q        <= 1'b0;
      locked_port_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      cnt0_q        <= cnt0_d;
      cnt1_q        <= cnt1_d;
      prio_q        <= prio_d;
      lock_q        <= lock_d;
      locked_port_q <= locked_port_d;
      err_q         <= err_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
  assign err  = err_q;

endmodule

// File: tb/tb_proc_mem_req_arbiter.sv
// Bench for proc_mem_req_arbiter: directed vectors, a per-cycle behavioural
// model comparison, and hand-computed literal checks.
module tb_proc_mem_req_arbiter;

  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        reset, domain, mem_domain;
  logic [76:0] in0_req_msg, in1_req_msg, out_req_msg;
  logic        in0_req_val, in0_req_rdy, in1_req_val, in1_req_rdy;
  logic        out_req_val, out_req_rdy;
  logic [44:0] mem_resp_msg, out0_resp_msg, out1_resp_msg;
  logic        mem_resp_val, mem_resp_rdy;
  logic        out0_resp_val, out0_resp_rdy, out1_resp_val, out1_resp_rdy;
  logic [3:0]  cnt0, cnt1;
  logic        err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  proc_mem_req_arbiter #(.p_max_outstanding(MAXO)) dut (
    .clk(clk), .reset(reset), .domain(domain), .mem_domain(mem_domain),
    .in0_req_msg(in0_req_msg), .in0_req_val(in0_req_val), .in0_req_rdy(in0_req_rdy),
    .in1_req_msg(in1_req_msg), .in1_req_val(in1_req_val), .in1_req_rdy(in1_req_rdy),
    .out_req_msg(out_req_msg), .out_req_val(out_req_val), .out_req_rdy(out_req_rdy),
    .mem_resp_msg(mem_resp_msg), .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy),
    .out0_resp_msg(out0_resp_msg), .out0_resp_val(out0_resp_val), .out0_resp_rdy(out0_resp_rdy),
    .out1_resp_msg(out1_resp_msg), .out1_resp_val(out1_resp_val), .out1_resp_rdy(out1_resp_rdy),
    .cnt0(cnt0), .cnt1(cnt1), .err(err)
  );

  task automatic chk(input string nm, input logic [76:0] act, input logic [76:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [76:0] mkreq(input logic [7:0] opq, input logic [31:0] addr,
                                        input logic [31:0] data);
    return {3'd0, opq, addr, 2'd0, data};
  endfunction

  function automatic logic [44:0] mkresp(input logic [7:0] opq, input logic [31:0] data);
    return {3'd1, opq, 2'd0, data};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model state: outstanding count per port, round-robin favourite, held grant, error.
  int   m_cnt [2];
  int   m_fav;
  bit   m_held;
  int   m_held_port;
  bit   m_err;

  int          g, p, n;
  bit          gv, el0, el1, rq_fire, rs_fire, sink_rdy;
  logic [76:0] exp_req;
  logic [44:0] exp_resp;

  always @(negedge clk) begin
    chk("m_domain", 77'(mem_domain), 77'(domain));
    if (reset) begin
      m_cnt[0] = 0; m_cnt[1] = 0; m_fav = 0; m_held = 0; m_held_port = 0; m_err = 0;
      chk("m_rst_out_val", 77'(out_req_val), 77'(0));
      chk("m_rst_in_rdy", 77'({in0_req_rdy, in1_req_rdy}), 77'(0));
      chk("m_rst_resp_val", 77'({out0_resp_val, out1_resp_val}), 77'(0));
      chk("m_rst_mem_rdy", 77'(mem_resp_rdy), 77'(0));
      chk("m_rst_cnt", 77'({cnt0, cnt1, err}), 77'(0));
    end else begin
      el0 = in0_req_val && (m_cnt[0] < MAXO);
      el1 = in1_req_val && (m_cnt[1] < MAXO);
      gv  = m_held || el0 || el1;
      if (m_held)          g = m_held_port;
      else if (el0 && el1) g = m_fav;
      else                 g = el1 ? 1 : 0;
      chk("m_out_val", 77'(out_req_val), 77'(gv));
      chk("m_in0_rdy", 77'(in0_req_rdy), 77'(gv && g == 0 && out_req_rdy));
      chk("m_in1_rdy", 77'(in1_req_rdy), 77'(gv && g == 1 && out_req_rdy));
      if (gv) begin
        exp_req = (g == 1) ? in1_req_msg : in0_req_msg;
        exp_req[73:66] = 8'(g);
        chk("m_out_msg", out_req_msg, exp_req);
      end
      p = int'(mem_resp_msg[34]);
      exp_resp = mem_resp_msg;
      exp_resp[41:34] = 8'h00;
      sink_rdy = (p == 1) ? out1_resp_rdy : out0_resp_rdy;
      chk("m_out0_val", 77'(out0_resp_val), 77'(mem_resp_val && p == 0));
      chk("m_out1_val", 77'(out1_resp_val), 77'(mem_resp_val && p == 1));
      chk("m_mem_rdy", 77'(mem_resp_rdy), 77'(sink_rdy));
      if (out0_resp_val) chk("m_out0_msg", 77'(out0_resp_msg), 77'(exp_resp));
      if (out1_resp_val) chk("m_out1_msg", 77'(out1_resp_msg), 77'(exp_resp));
      chk("m_cnt0", 77'(cnt0), 77'(m_cnt[0]));
      chk("m_cnt1", 77'(cnt1), 77'(m_cnt[1]));
      chk("m_err", 77'(err), 77'(m_err));

      rq_fire = gv && out_req_rdy;
      rs_fire = mem_resp_val && sink_rdy;
      if (rs_fire && m_cnt[p] == 0) m_err = 1;
      for (int i = 0; i < 2; i++) begin
        n = m_cnt[i] + ((rq_fire && g == i) ? 1 : 0) - ((rs_fire && p == i) ? 1 : 0);
        m_cnt[i] = (n < 0) ? 0 : ((n > MAXO) ? MAXO : n);
      end
      if (rq_fire) begin
        m_fav  = 1 - g;
        m_held = 0;
      end else if (gv) begin
        m_held      = 1;
        m_held_port = g;
      end
    end
  end

  task automatic clear_inputs();
    in0_req_val = 0; in1_req_val = 0; out_req_rdy = 0; mem_resp_val = 0;
    out0_resp_rdy = 0; out1_resp_rdy = 0;
    in0_req_msg = '0; in1_req_msg = '0; mem_resp_msg = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  int prev;

  initial begin
    domain = 0;
    clear_inputs();
    reset = 1;
    tick();
    #1;
    chk("rst_out_val", 77'(out_req_val), 77'(0));
    chk("rst_cnt", 77'({cnt0, cnt1, err}), 77'(0));
    tick();
    reset = 0;

    // Single transaction on port 0: request fires, response returns data.
    in0_req_val = 1; in0_req_msg = mkreq(8'h5A, 32'h200, 32'h0); out_req_rdy = 1;
    #1;
    chk("t1_val", 77'(out_req_val), 77'(1));
    chk("t1_opq", 77'(out_req_msg[73:66]), 77'(8'h00));
    chk("t1_addr", 77'(out_req_msg[65:34]), 77'(32'h200));
    chk("t1_rdy", 77'(in0_req_rdy), 77'(1));
    tick();
    chk("t1_cnt0", 77'(cnt0), 77'(1));
    in0_req_val = 0; domain = 1;
    mem_resp_val = 1; mem_resp_msg = mkresp(8'h00, 32'hDEADBEEF); out0_resp_rdy = 1;
    #1;
    chk("t1_rval", 77'({out0_resp_val, out1_resp_val}), 77'(2'b10));
    chk("t1_rdata", 77'(out0_resp_msg[31:0]), 77'(32'hDEADBEEF));
    tick();
    mem_resp_val = 0;
    #1;
    chk("t1_cnt0_done", 77'(cnt0), 77'(0));

    // Both ports streaming: grants alternate, responses route by source.
    do_reset();
    in0_req_val = 1; in0_req_msg = mkreq(8'h33, 32'h1000, 32'h11);
    in1_req_val = 1; in1_req_msg = mkreq(8'h44, 32'h2000, 32'h22);
    out_req_rdy = 1; out0_resp_rdy = 1; out1_resp_rdy = 1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        mem_resp_val = 1;
        mem_resp_msg = mkresp(8'(prev), 32'hA0 + 32'(k));
      end
      #1;
      chk("t2_grant", 77'(out_req_msg[73:66]), 77'(k % 2));
      if (k > 0)
        chk("t2_route", 77'({out1_resp_val, out0_resp_val}), 77'(prev == 1 ? 2'b10 : 2'b01));
      tick();
      prev = k % 2;
    end
    in0_req_val = 0; in1_req_val = 0;
    mem_resp_msg = mkresp(8'h01, 32'hB0);
    tick();
    mem_resp_val = 0;
    #1;
    chk("t2_cnt", 77'({cnt0, cnt1}), 77'(0));

    // Backpressure holds the in1 grant even after in0 arrives with priority.
    do_reset();
    in1_req_val = 1; in1_req_msg = mkreq(8'h01, 32'h3000, 32'h77);
    #1;
    chk("t3_c1", 77'(out_req_msg[73:66]), 77'(1));
    tick();
    in0_req_val = 1; in0_req_msg = mkreq(8'h00, 32'h4000, 32'h88);
    #1;
    chk("t3_c2_msg", out_req_msg, mkreq(8'h01, 32'h3000, 32'h77));
    chk("t3_c2_rdy0", 77'(in0_req_rdy), 77'(0));
    tick();
    #1;
    chk("t3_c3_msg", out_req_msg, mkreq(8'h01, 32'h3000, 32'h77));
    tick();
    out_req_rdy = 1;
    #1;
    chk("t3_c4_fire1", 77'({in1_req_rdy, in0_req_rdy}), 77'(2'b10));
    tick();
    in1_req_val = 0;
    #1;
    chk("t3_c5_grant0", 77'({out_req_msg[66], in0_req_rdy}), 77'(2'b01));
    tick();
    in0_req_val = 0;

    // Outstanding cap on port 0 while port 1 still flows.
    do_reset();
    in0_req_val = 1; in0_req_msg = mkreq(8'h00, 32'h500, 32'h0); out_req_rdy = 1;
    repeat (4) tick();
    chk("t4_cnt0_cap", 77'(cnt0), 77'(4));
    in1_req_val = 1; in1_req_msg = mkreq(8'h09, 32'h600, 32'h0);
    #1;
    chk("t4_rdy", 77'({in0_req_rdy, in1_req_rdy}), 77'(2'b01));
    chk("t4_grant1", 77'(out_req_msg[66]), 77'(1));
    tick();
    in1_req_val = 0;
    mem_resp_val = 1; mem_resp_msg = mkresp(8'h00, 32'h1); out0_resp_rdy = 1;
    #1;
    chk("t4_still_cap", 77'(in0_req_rdy), 77'(0));
    tick();
    mem_resp_val = 0;
    #1;
    chk("t4_cnt", 77'({cnt0, cnt1}), 77'({4'd3, 4'd1}));
    chk("t4_elig", 77'(in0_req_rdy), 77'(1));
    in0_req_val = 0;
    tick();

    // Same-cycle request and response fire on one port, then on different ports.
    do_reset();
    in0_req_val = 1; in0_req_msg = mkreq(8'h00, 32'h700, 32'h0); out_req_rdy = 1;
    out0_resp_rdy = 1;
    repeat (2) tick();
    chk("t5_cnt0_pre", 77'(cnt0), 77'(2));
    mem_resp_val = 1; mem_resp_msg = mkresp(8'h00, 32'h2);
    tick();
    chk("t5_same", 77'(cnt0), 77'(2));
    in0_req_val = 0; in1_req_val = 1; in1_req_msg = mkreq(8'h00, 32'h800, 32'h0);
    tick();
    in1_req_val = 0; mem_resp_val = 0;
    #1;
    chk("t5_diff", 77'({cnt0, cnt1}), 77'({4'd1, 4'd1}));

    // Orphan response, then reset asserted with state in flight.
    do_reset();
    mem_resp_val = 1; mem_resp_msg = mkresp(8'h01, 32'h5555); out1_resp_rdy = 1;
    #1;
    chk("t6_route", 77'({out1_resp_val, out0_resp_val}), 77'(2'b10));
    chk("t6_data", 77'(out1_resp_msg), 77'({3'd1, 8'h00, 2'd0, 32'h5555}));
    tick();
    mem_resp_val = 0;
    #1;
    chk("t6_err", 77'({err, cnt1}), 77'({1'b1, 4'd0}));
    in1_req_val = 1; in1_req_msg = mkreq(8'h00, 32'h900, 32'h0); out_req_rdy = 1;
    tick();
    chk("t6_err_held", 77'({err, cnt1}), 77'({1'b1, 4'd1}));
    in1_req_val = 0; in0_req_val = 1; in0_req_msg = mkreq(8'h00, 32'hA00, 32'h0);
    out_req_rdy = 0;
    tick();
    reset = 1;
    #1;
    chk("t6_rst_val", 77'({out_req_val, in0_req_rdy, mem_resp_rdy}), 77'(0));
    chk("t6_rst_state", 77'({err, cnt0, cnt1}), 77'(0));
    tick();
    reset = 0; in0_req_val = 0;
    in1_req_val = 1; in1_req_msg = mkreq(8'h00, 32'hB00, 32'h0);
    #1;
    chk("t6_unlocked", 77'({out_req_val, out_req_msg[66]}), 77'(2'b11));
    out_req_rdy = 1;
    tick();
    in1_req_val = 0;
    #1;
    chk("t6_final", 77'({err, cnt0, cnt1}), 77'({1'b0, 4'd0, 4'd1}));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
